// File: rtl/mmio_uart_ctrl_pkg.sv
// mmio_uart_ctrl_pkg: MMIO register addresses, TX FSM states and address-match helper
package mmio_uart_ctrl_pkg;
  localparam logic [31:0] MMIO_STATUS   = 32'h8000_0000;
  localparam logic [31:0] MMIO_RX_DATA  = 32'h8000_0004;
  localparam logic [31:0] MMIO_TX_DATA  = 32'h8000_0008;
  localparam logic [31:0] MMIO_CYC_CNT  = 32'h8000_0010;
  localparam logic [31:0] MMIO_INST_CNT = 32'h8000_0014;
  localparam logic [31:0] MMIO_CNT_RST  = 32'h8000_0018;
  localparam logic [31:0] MMIO_BR_CNT   = 32'h8000_001C;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;
  function automatic logic hit(input logic [29:0] w, input logic [31:0] r);
    return {w, 2'b00} == r;
  endfunction
endpackage

// File: rtl/mmio_uart_ctrl_if.sv
// mmio_uart_ctrl_if: load/store bus, retire strobes and UART handshakes of the MMIO block
interface mmio_uart_ctrl_if;
  logic [31:0] addr, wdata, rdata;
  logic mmio_we, mmio_re, inst_retire, branch_retire;
  logic [7:0] uart_tx_data, uart_rx_data;
  logic uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_ready;
  modport master(
    output addr, wdata, mmio_we, mmio_re, inst_retire, branch_retire,
    output uart_tx_ready, uart_rx_data, uart_rx_valid,
    input rdata, uart_tx_data, uart_tx_valid, uart_rx_ready
  );
  modport slave(
    input addr, wdata, mmio_we, mmio_re, inst_retire, branch_retire,
    input uart_tx_ready, uart_rx_data, uart_rx_valid,
    output rdata, uart_tx_data, uart_tx_valid, uart_rx_ready
  );
endinterface

// File: rtl/mmio_uart_ctrl_rx_fifo.sv
// mmio_rx_fifo: byte FIFO; pop on empty is ignored, push on full lands only alongside a pop
module mmio_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rptr];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      wptr <= wptr + AW'(do_push);
      rptr <= rptr + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl: MMIO regs, UART TX/RX, perf counters; MMIO_BRANCH_CNT_EN adds a branch counter
module mmio_uart_ctrl
  import mmio_uart_ctrl_pkg::*;
#(
  parameter int RX_DEPTH = 8,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  mmio_uart_ctrl_if.slave bus
);
  tx_state_t tx_state;
  logic tx_valid, tx_drop, rx_full, rx_empty, rx_ready, rd_rx, rd_stat, wr_tx, cnt_rst;
  logic [7:0] tx_data, rx_head;
  logic [29:0] a;
  logic [31:0] rd_val, rdata, br_val;
  logic [CNT_W-1:0] cyc_cnt, inst_cnt;
  assign a = bus.addr[31:2];
  assign rd_stat = bus.mmio_re && hit(a, MMIO_STATUS);
  assign rd_rx = bus.mmio_re && hit(a, MMIO_RX_DATA);
  assign wr_tx = bus.mmio_we && hit(a, MMIO_TX_DATA);
  assign cnt_rst = bus.mmio_we && hit(a, MMIO_CNT_RST);
  // a pop frees the head slot this cycle, so a full FIFO can still take a byte
  assign rx_ready = !rx_full || rd_rx;
  assign bus.uart_rx_ready = rx_ready;
  assign bus.uart_tx_valid = tx_valid;
  assign bus.uart_tx_data = tx_data;
  assign bus.rdata = rdata;
  mmio_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx (
    .clk(clk),
    .rst_n(rst_n),
    .push(bus.uart_rx_valid && rx_ready),
    .pop(rd_rx),
    .din(bus.uart_rx_data),
    .full(rx_full),
    .empty(rx_empty),
    .head(rx_head)
  );
  always_comb
    rd_val = hit(a, MMIO_STATUS)   ? {29'b0, tx_drop, !rx_empty, !tx_valid} :
             hit(a, MMIO_RX_DATA)  ? {24'b0, rx_empty ? 8'h00 : rx_head} :
             hit(a, MMIO_CYC_CNT)  ? cyc_cnt :
             hit(a, MMIO_INST_CNT) ? inst_cnt :
             hit(a, MMIO_BR_CNT)   ? br_val : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else rdata <= bus.mmio_re ? rd_val : rdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cyc_cnt <= '0;
      inst_cnt <= '0;
    end else begin
      cyc_cnt <= cnt_rst ? '0 : cyc_cnt + CNT_W'(1);
      inst_cnt <= cnt_rst ? '0 : inst_cnt + CNT_W'(bus.inst_retire);
    end
`ifdef MMIO_BRANCH_CNT_EN
  logic [CNT_W-1:0] br_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) br_cnt <= '0;
    else br_cnt <= cnt_rst ? '0 : br_cnt + CNT_W'(bus.branch_retire);
  assign br_val = br_cnt;
`else
  assign br_val = '0;
`endif
  // stores while BUSY are dropped even when the handshake completes that same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_valid <= 1'b0;
      tx_data <= '0;
      tx_drop <= 1'b0;
    end else begin
      tx_drop <= (wr_tx && tx_state == TX_BUSY) || (tx_drop && !rd_stat);
      if (tx_state == TX_IDLE && wr_tx) begin
        tx_state <= TX_BUSY;
        tx_valid <= 1'b1;
        tx_data <= bus.wdata[7:0];
      end else if (tx_state == TX_BUSY && bus.uart_tx_ready) begin
        tx_state <= TX_IDLE;
        tx_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// tb_mmio_uart_ctrl: vector table, directed corner sequences and random traffic against a queue model
module tb_mmio_uart_ctrl;
  import mmio_uart_ctrl_pkg::*;
  localparam int D = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mmio_uart_ctrl_if bus();
  mmio_uart_ctrl #(.RX_DEPTH(D), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  logic [7:0] m_q[$];
  logic m_busy, m_drop;
  logic [7:0] m_txd;
  logic [31:0] m_cyc, m_inst, m_rdata;

  typedef struct {
    logic we, re;
    logic [31:0] a, wd;
    logic rxv;
    logic [7:0] rxd;
    logic txr;
    logic [31:0] er;
    logic etv;
    logic [7:0] etd;
  } vec_t;
  vec_t tbl[18];
  logic [31:0] alist[10] = '{MMIO_STATUS, MMIO_RX_DATA, MMIO_RX_DATA, MMIO_TX_DATA, MMIO_CYC_CNT,
                             MMIO_INST_CNT, MMIO_CNT_RST, MMIO_BR_CNT, 32'h8000_000C, 32'h1234_5678};

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [31:0] w);
    if (w == MMIO_STATUS) return {29'b0, m_drop, m_q.size() != 0, !m_busy};
    if (w == MMIO_RX_DATA) return m_q.size() != 0 ? {24'b0, m_q[0]} : 32'h0;
    if (w == MMIO_CYC_CNT) return m_cyc;
    if (w == MMIO_INST_CNT) return m_inst;
    return 32'h0;
  endfunction

  task automatic mreset();
    m_q.delete();
    m_busy = 0; m_drop = 0; m_txd = 0;
    m_cyc = 0; m_inst = 0; m_rdata = 0;
  endtask

  task automatic drive0();
    bus.mmio_we = 0; bus.mmio_re = 0; bus.addr = 0; bus.wdata = 0;
    bus.inst_retire = 0; bus.branch_retire = 0;
    bus.uart_rx_valid = 0; bus.uart_rx_data = 0; bus.uart_tx_ready = 0;
  endtask

  // one clock: drive at negedge, check ready before the edge, update model, check outputs after
  task automatic cyc(input logic we, input logic re, input logic [31:0] a, input logic [31:0] wd,
                     input logic ret, input logic rxv, input logic [7:0] rxd, input logic txr);
    logic [31:0] w, rv;
    logic rdy, pop;
    bus.mmio_we = we; bus.mmio_re = re; bus.addr = a; bus.wdata = wd;
    bus.inst_retire = ret; bus.branch_retire = $urandom_range(0, 1) == 1;
    bus.uart_rx_valid = rxv; bus.uart_rx_data = rxd; bus.uart_tx_ready = txr;
    w = {a[31:2], 2'b00};
    pop = re && w == MMIO_RX_DATA && m_q.size() != 0;
    rdy = m_q.size() < D || (re && w == MMIO_RX_DATA);
    rv = mread(w);
    #1 chk("rx_ready", 32'(bus.uart_rx_ready), 32'(rdy));
    @(posedge clk);
    #1;
    if (re) m_rdata = rv;
    if (pop) void'(m_q.pop_front());
    if (rxv && rdy) m_q.push_back(rxd);
    if (re && w == MMIO_STATUS) m_drop = 0;
    if (we && w == MMIO_TX_DATA && m_busy) m_drop = 1;
    if (m_busy) begin
      if (txr) m_busy = 0;
    end else if (we && w == MMIO_TX_DATA) begin
      m_busy = 1;
      m_txd = wd[7:0];
    end
    if (we && w == MMIO_CNT_RST) begin
      m_cyc = 0;
      m_inst = 0;
    end else begin
      m_cyc = m_cyc + 1;
      m_inst = m_inst + 32'(ret);
    end
    chk("rdata", bus.rdata, m_rdata);
    chk("tx_valid", 32'(bus.uart_tx_valid), 32'(m_busy));
    chk("tx_data", 32'(bus.uart_tx_data), 32'(m_txd));
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{0, 1, MMIO_STATUS, 0, 0, 0, 0, 32'h1, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 1, 8'h41, 0, 32'h1, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 1, 8'h42, 0, 32'h1, 0, 0};
    tbl[3]  = '{0, 1, MMIO_STATUS, 0, 0, 0, 0, 32'h3, 0, 0};
    tbl[4]  = '{0, 1, 32'h8000_0006, 0, 0, 0, 0, 32'h41, 0, 0};
    tbl[5]  = '{0, 1, MMIO_RX_DATA, 0, 0, 0, 0, 32'h42, 0, 0};
    tbl[6]  = '{0, 1, MMIO_RX_DATA, 0, 0, 0, 0, 32'h0, 0, 0};
    tbl[7]  = '{0, 1, MMIO_STATUS, 0, 0, 0, 0, 32'h1, 0, 0};
    tbl[8]  = '{1, 0, MMIO_TX_DATA, 32'h155, 0, 0, 0, 32'h1, 1, 8'h55};
    tbl[9]  = '{0, 1, MMIO_STATUS, 0, 0, 0, 0, 32'h0, 1, 8'h55};
    tbl[10] = '{1, 0, MMIO_TX_DATA, 32'h66, 0, 0, 0, 32'h0, 1, 8'h55};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 8'h55};
    tbl[12] = '{0, 1, MMIO_STATUS, 0, 0, 0, 0, 32'h5, 0, 8'h55};
    tbl[13] = '{0, 1, MMIO_STATUS, 0, 0, 0, 0, 32'h1, 0, 8'h55};
    tbl[14] = '{0, 1, MMIO_BR_CNT, 0, 0, 0, 0, 32'h0, 0, 8'h55};
    tbl[15] = '{0, 1, MMIO_STATUS, 0, 0, 0, 0, 32'h1, 0, 8'h55};
    tbl[16] = '{1, 0, MMIO_STATUS, 32'hFFFF_FFFF, 0, 0, 0, 32'h1, 0, 8'h55};
    tbl[17] = '{0, 1, 32'h8000_000C, 0, 0, 0, 0, 32'h0, 0, 8'h55};

    drive0();
    mreset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_tx_valid", 32'(bus.uart_tx_valid), 32'h0);
    chk("reset_tx_data", 32'(bus.uart_tx_data), 32'h0);
    chk("reset_rx_ready", 32'(bus.uart_rx_ready), 32'h1);

    foreach (tbl[i]) begin
      cyc(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].wd, 0, tbl[i].rxv, tbl[i].rxd, tbl[i].txr);
      chk($sformatf("tbl%0d_rdata", i), bus.rdata, tbl[i].er);
      chk($sformatf("tbl%0d_txv", i), 32'(bus.uart_tx_valid), 32'(tbl[i].etv));
      chk($sformatf("tbl%0d_txd", i), 32'(bus.uart_tx_data), 32'(tbl[i].etd));
    end

    // fill the FIFO, then push and pop together while full
    for (int i = 0; i < D; i++) cyc(0, 0, 0, 0, 0, 1, 8'hA0 + 8'(i), 0);
    bus.uart_rx_valid = 0;
    #1 chk("full_rx_ready", 32'(bus.uart_rx_ready), 32'h0);
    cyc(0, 1, MMIO_RX_DATA, 0, 0, 1, 8'hEE, 0);
    chk("full_pushpop_rdata", bus.rdata, 32'hA0);
    bus.mmio_re = 0; bus.uart_rx_valid = 0;
    #1 chk("full_pushpop_ready", 32'(bus.uart_rx_ready), 32'h0);
    for (int i = 0; i < D; i++) cyc(0, 1, MMIO_RX_DATA, 0, 0, 0, 0, 0);
    chk("drain_last", bus.rdata, 32'hEE);
    cyc(0, 1, MMIO_STATUS, 0, 0, 0, 0, 0);
    chk("drain_status", bus.rdata, 32'h1);

    // TX held off for five cycles with a dropped second store
    cyc(1, 0, MMIO_TX_DATA, 32'h55, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(i == 2, 0, MMIO_TX_DATA, 32'h66, 0, 0, 0, 0);
      chk("hold_txv", 32'(bus.uart_tx_valid), 32'h1);
      chk("hold_txd", 32'(bus.uart_tx_data), 32'h55);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, MMIO_STATUS, 0, 0, 0, 0, 0);
    chk("drop_status", bus.rdata, 32'h5);
    cyc(0, 1, MMIO_STATUS, 0, 0, 0, 0, 0);
    chk("drop_cleared", bus.rdata, 32'h1);

    // counters
    cyc(1, 0, MMIO_CNT_RST, 0, 0, 0, 0, 1);
    for (int i = 0; i < 100; i++) cyc(0, 0, 0, 0, i < 40, 0, 0, 1);
    cyc(0, 1, MMIO_CYC_CNT, 0, 0, 0, 0, 1);
    chk("cyc_100", bus.rdata, 32'd100);
    cyc(0, 1, MMIO_INST_CNT, 0, 0, 0, 0, 1);
    chk("inst_40", bus.rdata, 32'd40);
    cyc(1, 0, MMIO_CNT_RST, 32'hDEAD, 1, 0, 0, 1);
    cyc(0, 1, MMIO_CYC_CNT, 0, 0, 0, 0, 1);
    chk("cyc_cleared", bus.rdata, 32'h0);
    cyc(0, 1, MMIO_INST_CNT, 0, 0, 0, 0, 1);
    chk("inst_cleared", bus.rdata, 32'h0);

    // instruction counter wrap
    force dut.inst_cnt = 32'hFFFF_FFFF;
    m_inst = 32'hFFFF_FFFF;
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    release dut.inst_cnt;
    cyc(0, 0, 0, 0, 1, 0, 0, 1);
    cyc(0, 1, MMIO_INST_CNT, 0, 0, 0, 0, 1);
    chk("inst_wrap", bus.rdata, 32'h0);

    // asynchronous reset in the middle of a TX transfer
    cyc(0, 0, 0, 0, 0, 1, 8'h77, 0);
    cyc(1, 1, MMIO_TX_DATA, 32'hA5, 0, 0, 0, 0);
    chk("pre_rst_txv", 32'(bus.uart_tx_valid), 32'h1);
    drive0();
    #2 rst_n = 0;
    #1;
    chk("async_rst_txv", 32'(bus.uart_tx_valid), 32'h0);
    chk("async_rst_rdata", bus.rdata, 32'h0);
    mreset();
    @(negedge clk);
    rst_n = 1;
    cyc(0, 1, MMIO_RX_DATA, 0, 0, 0, 0, 0);
    chk("rst_fifo_empty", bus.rdata, 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
          alist[$urandom_range(0, 9)] | 32'($urandom_range(0, 3)), $urandom,
          $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) == 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
